// File: rtl/fb_ctrl_pkg.sv
// Shared frame-buffer controller definitions: FSM state encoding, frame index
// width helper and the default line geometry used by both write and read sides.
package fb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEL      = 3'd1,
    ST_WAIT_SOF = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DRAIN    = 3'd4
  } fb_state_e;

  localparam int unsigned FB_DEF_LINE_STRIDE = 32'h0000_2000;
  localparam int unsigned FB_DEF_LINE_SIZE   = 32'd64;

  // Width of a frame index for a ring of 'frames' buffers (at least 1 bit).
  function automatic int frame_idx_w(input int frames);
    return (frames > 1) ? $clog2(frames) : 1;
  endfunction

endpackage

// File: rtl/fb_frame_sel.sv
// Next frame index selection for a ring of FRAMES_CNT buffers. Steps to the
// following index, skipping the one currently held by the other side; if the
// skip would still land on the held frame (two-frame ring) the current index
// is kept.
module fb_frame_sel
  import fb_ctrl_pkg::*;
#(
  parameter int FRAMES_CNT = 3
) (
  input  logic [frame_idx_w(FRAMES_CNT)-1:0] cur_i,
  input  logic [frame_idx_w(FRAMES_CNT)-1:0] avoid_i,
  input  logic                               avoid_en_i,
  output logic [frame_idx_w(FRAMES_CNT)-1:0] nxt_o
);

  localparam int FW = frame_idx_w(FRAMES_CNT);

  function automatic logic [FW-1:0] ring_inc(input logic [FW-1:0] x);
    return (x == FW'(FRAMES_CNT - 1)) ? '0 : x + FW'(1);
  endfunction

  logic [FW-1:0] step1;
  logic [FW-1:0] step2;

  // Pick the next frame, stepping over the held one at most once.
  always_comb begin
    step1 = ring_inc(cur_i);
    step2 = ring_inc(step1);
    nxt_o = step1;
    if (avoid_en_i && (step1 == avoid_i)) begin
      nxt_o = (step2 == avoid_i) ? cur_i : step2;
    end
  end

endmodule

// File: rtl/fb_wr_ctrl.sv
// Frame-buffer write sequencer. Snoops the video stream, hands per-line
// address/size to the stream-to-memory converter, rotates through a ring of
// frame buffers avoiding the reader's frame, and publishes a frame once all
// of its line writes have been acknowledged.
// Handshake: a beat transfers only in a cycle where s_tvalid_i and
// s_tready_i are both high; tuser on a beat marks start of frame, tlast on a
// beat marks end of line. stall_o asks the upstream to hold tready low.
// Optional statistics outputs are built when FB_WR_CTRL_STATS_EN is defined.
module fb_wr_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PKT_SIZE_W = 14,
  parameter int LINE_CNT_W = 12,
  parameter int FRAMES_CNT = 3,
  parameter int OUTSTD_W   = 6
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               en_i,
  input  logic [ADDR_WIDTH-1:0]              base_addr_i,
  input  logic [ADDR_WIDTH-1:0]              frame_size_i,
  input  logic [15:0]                        line_stride_i,
  input  logic [PKT_SIZE_W-1:0]              line_size_i,
  input  logic [LINE_CNT_W-1:0]              lines_i,
  input  logic                               s_tvalid_i,
  input  logic                               s_tready_i,
  input  logic                               s_tuser_i,
  input  logic                               s_tlast_i,
  input  logic                               line_done_i,
  input  logic [frame_idx_w(FRAMES_CNT)-1:0] rd_frame_i,
  input  logic                               rd_active_i,
  output logic                               pass_o,
  output logic                               stall_o,
  output logic [ADDR_WIDTH-1:0]              addr_o,
  output logic [PKT_SIZE_W-1:0]              pkt_size_o,
  output logic [frame_idx_w(FRAMES_CNT)-1:0] wr_frame_o,
  output logic [frame_idx_w(FRAMES_CNT)-1:0] done_frame_o,
  output logic                               done_valid_o,
  output logic                               drop_o
`ifdef FB_WR_CTRL_STATS_EN
  ,
  output logic [15:0]                        frames_ok_o,
  output logic [15:0]                        frames_drop_o
`endif
);

  localparam int FW = frame_idx_w(FRAMES_CNT);
  localparam logic [OUTSTD_W-1:0] OUT_MAX = '1;

  fb_state_e             state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PKT_SIZE_W-1:0] pkt_q;
  logic [FW-1:0]         wr_frame_q;
  logic [FW-1:0]         done_frame_q;
  logic                  done_valid_q;
  logic                  drop_q;
  logic [LINE_CNT_W-1:0] line_cnt_q;
  logic                  bad_q;
  logic [OUTSTD_W-1:0]   out_q;
  logic [OUTSTD_W-1:0]   out_d;

  logic                  beat;
  logic                  sof;
  logic                  eol;
  logic                  acc_eol;
  logic                  line_last;
  logic                  drain_done;
  logic [FW-1:0]         sel_frame;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [ADDR_WIDTH-1:0] stride_ext;

  fb_frame_sel #(
    .FRAMES_CNT(FRAMES_CNT)
  ) u_frame_sel (
    .cur_i      (wr_frame_q),
    .avoid_i    (rd_frame_i),
    .avoid_en_i (rd_active_i),
    .nxt_o      (sel_frame)
  );

  assign beat       = s_tvalid_i & s_tready_i;
  assign sof        = beat & s_tuser_i;
  assign eol        = beat & s_tlast_i;
  // Only line ends of beats routed to the converter count as issued writes.
  assign acc_eol    = eol & ((state_q == ST_WRITE) || ((state_q == ST_WAIT_SOF) && s_tuser_i));
  assign line_last  = ((line_cnt_q + LINE_CNT_W'(1)) == lines_i);
  assign drain_done = (state_q == ST_DRAIN) && (out_q == '0);
  assign stride_ext = ADDR_WIDTH'(line_stride_i);
  assign sel_base   = base_addr_i + ADDR_WIDTH'(sel_frame) * frame_size_i;

  assign pass_o       = (state_q == ST_WRITE) || ((state_q == ST_WAIT_SOF) && s_tuser_i);
  assign stall_o      = (state_q == ST_DRAIN) || ((state_q == ST_WRITE) && (out_q == OUT_MAX));
  assign addr_o       = addr_q;
  assign pkt_size_o   = pkt_q;
  assign wr_frame_o   = wr_frame_q;
  assign done_frame_o = done_frame_q;
  assign done_valid_o = done_valid_q;
  assign drop_o       = drop_q;

  // Outstanding line writes: up on an issued line, down on its completion.
  always_comb begin
    out_d = out_q;
    if (acc_eol && !line_done_i && (out_q != OUT_MAX)) begin
      out_d = out_q + OUTSTD_W'(1);
    end else if (!acc_eol && line_done_i && (out_q != '0)) begin
      out_d = out_q - OUTSTD_W'(1);
    end
  end

  // Outstanding counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) out_q <= '0;
    else          out_q <= out_d;
  end

  // Frame sequencing FSM with registered address, size and frame outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      pkt_q        <= '0;
      wr_frame_q   <= '0;
      done_frame_q <= '0;
      done_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      line_cnt_q   <= '0;
      bad_q        <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (en_i) state_q <= ST_SEL;
        end
        ST_SEL: begin
          wr_frame_q <= sel_frame;
          addr_q     <= sel_base;
          pkt_q      <= line_size_i;
          line_cnt_q <= '0;
          bad_q      <= 1'b0;
          state_q    <= ST_WAIT_SOF;
        end
        ST_WAIT_SOF, ST_WRITE: begin
          if (state_q == ST_WAIT_SOF && sof) state_q <= ST_WRITE;
          if (state_q == ST_WRITE && sof && (line_cnt_q != '0)) bad_q <= 1'b1;
          if (acc_eol) begin
            line_cnt_q <= line_cnt_q + LINE_CNT_W'(1);
            addr_q     <= addr_q + stride_ext;
            if (line_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            if (bad_q) begin
              drop_q <= 1'b1;
            end else begin
              done_frame_q <= wr_frame_q;
              done_valid_q <= 1'b1;
            end
            state_q <= en_i ? ST_SEL : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef FB_WR_CTRL_STATS_EN
  logic [15:0] ok_cnt_q;
  logic [15:0] drop_cnt_q;

  // Published / dropped frame counters, wrapping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ok_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else if (drain_done) begin
      if (bad_q) drop_cnt_q <= drop_cnt_q + 16'd1;
      else       ok_cnt_q   <= ok_cnt_q + 16'd1;
    end
  end

  assign frames_ok_o   = ok_cnt_q;
  assign frames_drop_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fb_wr_ctrl.sv
// Directed bench for fb_wr_ctrl: a vector table for the first frame plus
// hand-written sequences for ring rotation, reader avoidance, corrupt frames,
// delayed write completion and asynchronous reset.
module tb_fb_wr_ctrl;
  import fb_ctrl_pkg::*;

  localparam int AW = 32;
  localparam int PW = 14;
  localparam int LW = 12;
  localparam int FC = 3;
  localparam int OW = 6;
  localparam int FW = 2;
  localparam logic [31:0] STRIDE = FB_DEF_LINE_STRIDE;
  localparam logic [31:0] FSIZE  = 32'h0010_0000;

  logic          clk_i;
  logic          rst_n_i;
  logic          en_i;
  logic [AW-1:0] base_addr_i;
  logic [AW-1:0] frame_size_i;
  logic [15:0]   line_stride_i;
  logic [PW-1:0] line_size_i;
  logic [LW-1:0] lines_i;
  logic          s_tvalid_i, s_tready_i, s_tuser_i, s_tlast_i;
  logic          line_done_i;
  logic [FW-1:0] rd_frame_i;
  logic          rd_active_i;
  logic          pass_o, stall_o;
  logic [AW-1:0] addr_o;
  logic [PW-1:0] pkt_size_o;
  logic [FW-1:0] wr_frame_o, done_frame_o;
  logic          done_valid_o, drop_o;
`ifdef FB_WR_CTRL_STATS_EN
  logic [15:0]   frames_ok_o, frames_drop_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];

  fb_wr_ctrl #(
    .ADDR_WIDTH(AW), .PKT_SIZE_W(PW), .LINE_CNT_W(LW), .FRAMES_CNT(FC), .OUTSTD_W(OW)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i),
    .base_addr_i(base_addr_i), .frame_size_i(frame_size_i),
    .line_stride_i(line_stride_i), .line_size_i(line_size_i), .lines_i(lines_i),
    .s_tvalid_i(s_tvalid_i), .s_tready_i(s_tready_i), .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i),
    .line_done_i(line_done_i), .rd_frame_i(rd_frame_i), .rd_active_i(rd_active_i),
    .pass_o(pass_o), .stall_o(stall_o), .addr_o(addr_o), .pkt_size_o(pkt_size_o),
    .wr_frame_o(wr_frame_o), .done_frame_o(done_frame_o), .done_valid_o(done_valid_o),
    .drop_o(drop_o)
`ifdef FB_WR_CTRL_STATS_EN
    , .frames_ok_o(frames_ok_o), .frames_drop_o(frames_drop_o)
`endif
  );

  // Clock.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v, u, l, ld;
    logic        ex_pass, ex_stall;
    logic [31:0] ex_addr;
    logic        ex_dv;
    logic [1:0]  ex_df;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic v, input logic u, input logic l, input logic ld,
                              input logic p, input logic s, input logic [31:0] a,
                              input logic dv, input logic [1:0] df);
    vec_t r;
    r.v = v; r.u = u; r.l = l; r.ld = ld;
    r.ex_pass = p; r.ex_stall = s; r.ex_addr = a; r.ex_dv = dv; r.ex_df = df;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic u, input logic l);
    s_tvalid_i = v; s_tready_i = v; s_tuser_i = u; s_tlast_i = l;
  endtask

  // One beat per line (tlast on every beat); SOF on line 0 and on bad_line.
  task automatic write_frame(input logic [31:0] base, input logic [1:0] frm, input int bad_line);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) || (i == bad_line), 1'b1);
      @(negedge clk_i);
      chk("wr_pass", pass_o, 1);
      chk("wr_stall", stall_o, 0);
      chk("wr_addr", addr_o, base + 32'(i) * STRIDE);
      chk("wr_frame", wr_frame_o, frm);
      chk("wr_pkt", pkt_size_o, 64);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Hold in drain for 'delay' cycles, retire four lines, then check publish/drop.
  task automatic finish_frame(input logic bad, input int delay, input logic dv_before);
    logic [FW-1:0] exp_df;
    for (int c = 0; c < delay; c++) begin
      @(negedge clk_i);
      chk("hold_stall", stall_o, 1);
      chk("hold_pass", pass_o, 0);
      chk("hold_dv", done_valid_o, dv_before);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      line_done_i = 1'b1;
      @(negedge clk_i);
      chk("drain_stall", stall_o, 1);
      tick();
    end
    line_done_i = 1'b0;
    @(negedge clk_i);
    chk("drain_last_stall", stall_o, 1);
    chk("drain_no_drop_yet", drop_o, 0);
    tick();
    @(negedge clk_i);
    chk("post_stall", stall_o, 0);
    chk("post_drop", drop_o, bad);
    chk("post_dv", done_valid_o, 1);
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 1, 0);
    end else begin
      exp_df = exp_q.pop_front();
      chk("post_done_frame", done_frame_o, exp_df);
    end
    tick();
  endtask

  initial begin
    rst_n_i = 1'b1;
    en_i = 1'b0;
    base_addr_i = 32'h0;
    frame_size_i = FSIZE;
    line_stride_i = STRIDE[15:0];
    line_size_i = PW'(FB_DEF_LINE_SIZE);
    lines_i = LW'(4);
    drive(1'b0, 1'b0, 1'b0);
    line_done_i = 1'b0;
    rd_frame_i = '0;
    rd_active_i = 1'b0;
    #1 rst_n_i = 1'b0;

    // Reset values.
    @(negedge clk_i);
    chk("rst_pass", pass_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_pkt", pkt_size_o, 0);
    chk("rst_wr_frame", wr_frame_o, 0);
    chk("rst_done_frame", done_frame_o, 0);
    chk("rst_dv", done_valid_o, 0);
    chk("rst_drop", drop_o, 0);
    rst_n_i = 1'b1;
    tick();

    // Beats before enable are discarded.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, i == 2);
      @(negedge clk_i);
      chk("idle_pass", pass_o, 0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    en_i = 1'b1;
    tick();
    // SEL cycle: a SOF-looking beat is still not passed.
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("sel_pass", pass_o, 0);
    tick();

    // First frame (frame 1) as a vector table, two beats per line.
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0010_0000, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 1, 0, 32'h0010_0000, 0, 0);
    vecs[2]  = mk(1, 0, 1, 0, 1, 0, 32'h0010_0000, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 1, 0, 32'h0010_2000, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 1, 0, 32'h0010_2000, 0, 0);
    vecs[5]  = mk(1, 0, 1, 0, 1, 0, 32'h0010_2000, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 1, 0, 32'h0010_4000, 0, 0);
    vecs[7]  = mk(1, 0, 1, 1, 1, 0, 32'h0010_4000, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 1, 0, 32'h0010_6000, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 1, 0, 32'h0010_6000, 0, 0);
    vecs[10] = mk(0, 0, 0, 1, 0, 1, 32'h0010_8000, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 0, 1, 32'h0010_8000, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 1, 32'h0010_8000, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 32'h0010_8000, 1, 1);
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].v, vecs[i].u, vecs[i].l);
      line_done_i = vecs[i].ld;
      @(negedge clk_i);
      chk($sformatf("v%0d_pass", i), pass_o, vecs[i].ex_pass);
      chk($sformatf("v%0d_stall", i), stall_o, vecs[i].ex_stall);
      chk($sformatf("v%0d_addr", i), addr_o, vecs[i].ex_addr);
      chk($sformatf("v%0d_dv", i), done_valid_o, vecs[i].ex_dv);
      chk($sformatf("v%0d_df", i), done_frame_o, vecs[i].ex_df);
      chk($sformatf("v%0d_drop", i), drop_o, 0);
      chk($sformatf("v%0d_wr_frame", i), wr_frame_o, 1);
      chk($sformatf("v%0d_pkt", i), pkt_size_o, 64);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    line_done_i = 1'b0;

    // Ring continues: frame 2, then frame 0.
    exp_q.push_back(2'd2);
    write_frame(32'h0020_0000, 2'd2, -1);
    finish_frame(1'b0, 0, 1'b1);
    exp_q.push_back(2'd0);
    write_frame(32'h0000_0000, 2'd0, -1);
    finish_frame(1'b0, 0, 1'b1);

    // Reader holds frame 2: after frame 1 the writer must skip to frame 0.
    rd_frame_i = 2'd2;
    rd_active_i = 1'b1;
    exp_q.push_back(2'd1);
    write_frame(32'h0010_0000, 2'd1, -1);
    finish_frame(1'b0, 0, 1'b1);
    exp_q.push_back(2'd0);
    write_frame(32'h0000_0000, 2'd0, -1);
    rd_active_i = 1'b0;
    finish_frame(1'b0, 0, 1'b1);

    // Corrupt frame (SOF on line 2) with enable dropped mid-frame.
    en_i = 1'b0;
    exp_q.push_back(2'd0);
    write_frame(32'h0010_0000, 2'd1, 2);
    finish_frame(1'b1, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      @(negedge clk_i);
      chk("idle2_pass", pass_o, 0);
      chk("idle2_drop", drop_o, 0);
      chk("idle2_wr_frame", wr_frame_o, 1);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);

    // Re-enable; frame 2 with write completions delayed 50 cycles.
    en_i = 1'b1;
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b1);
    @(negedge clk_i);
    chk("wait_sof_pass", pass_o, 0);
    tick();
    exp_q.push_back(2'd2);
    write_frame(32'h0020_0000, 2'd2, -1);
    finish_frame(1'b0, 50, 1'b1);

    // Asynchronous reset in the middle of frame 0.
    drive(1'b1, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("pre_rst_addr", addr_o, 0);
    chk("pre_rst_pass", pass_o, 1);
    tick();
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_pass", pass_o, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_addr", addr_o, 0);
    chk("arst_pkt", pkt_size_o, 0);
    chk("arst_wr_frame", wr_frame_o, 0);
    chk("arst_done_frame", done_frame_o, 0);
    chk("arst_dv", done_valid_o, 0);
    chk("arst_drop", drop_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    tick();
    exp_q.push_back(2'd1);
    write_frame(32'h0010_0000, 2'd1, -1);
    finish_frame(1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_wr_ctrl.md
Name: fb_wr_ctrl

Overview:
Write-side sequencer for the frame buffer; sits in front of axi4_stream_to_axi4 and drives its addr_i/pkt_size_i per video line. Snoops the video AXI4-Stream handshake (tuser = SOF, tlast = EOL) and manages a ring of FRAMES_CNT frame buffers in memory. Avoids the frame the reader holds, and publishes the last fully written frame once all line write responses have returned.

Parameters:
ADDR_WIDTH, 32, byte address width
PKT_SIZE_W, 14, width of line size / pkt_size
LINE_CNT_W, 12, width of line counter
FRAMES_CNT, 3, number of frame buffers in ring (>=2)
OUTSTD_W, 6, width of outstanding-line-write counter

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  enable; sampled only in IDLE and at frame boundaries
base_addr_i  in  ADDR_WIDTH  address of frame 0
frame_size_i  in  ADDR_WIDTH  byte distance between frames
line_stride_i  in  16  byte distance between lines
line_size_i  in  PKT_SIZE_W  bytes per line
lines_i  in  LINE_CNT_W  lines per frame (>=1)
s_tvalid_i / s_tready_i / s_tuser_i / s_tlast_i  in  1 each  snooped stream handshake
line_done_i  in  1  one pulse per completed line write (last B response)
rd_frame_i  in  $clog2(FRAMES_CNT)  frame held by reader
rd_active_i  in  1  rd_frame_i is valid
pass_o  out  1  1 = route beats to converter, 0 = discard
stall_o  out  1  1 = deassert upstream tready
addr_o  out  ADDR_WIDTH  line start address to converter
pkt_size_o  out  PKT_SIZE_W  line size to converter
wr_frame_o  out  $clog2(FRAMES_CNT)  frame being written
done_frame_o  out  $clog2(FRAMES_CNT)  last complete frame
done_valid_o  out  1  done_frame_o valid (sticky after first frame)
drop_o  out  1  one-cycle pulse per frame dropped/corrupt

Behaviour:
- Reset: state IDLE; pass_o=0, stall_o=0, addr_o=0, pkt_size_o=0, wr_frame_o=0, done_frame_o=0, done_valid_o=0, drop_o=0; counters 0.
- Beat = s_tvalid_i & s_tready_i. EOL = beat & s_tlast_i. SOF = beat & s_tuser_i.
- IDLE: pass_o=0; en_i -> SEL.
- SEL (1 cycle): next = (wr_frame+1) mod FRAMES_CNT; if rd_active_i & next==rd_frame_i, next advances once more. If it still collides (FRAMES_CNT=2), keep the current wr_frame. Register frame_base = base_addr_i + next*frame_size_i (registered multiply). Set addr_o=frame_base, pkt_size_o=line_size_i, line_cnt=0, bad=0. -> WAIT_SOF.
- WAIT_SOF: pass_o = s_tuser_i (combinational), so non-SOF beats are discarded. On SOF -> WRITE; the SOF beat itself is passed.
- WRITE: pass_o=1. Each EOL: line_cnt+1, addr_o += line_stride_i, outstanding+1. A SOF with line_cnt!=0 sets bad=1 and the frame continues. The EOL making line_cnt==lines_i -> DRAIN.
- DRAIN: stall_o=1, pass_o=0. Wait for outstanding==0.
  - Not bad: done_frame_o=wr_frame, done_valid_o=1.
  - Bad: drop_o pulse.
  - Then en_i ? SEL : IDLE.
- outstanding: +1 on EOL, -1 on line_done_i; simultaneous -> unchanged. It never exceeds 2^OUTSTD_W-1; at that value stall_o=1 in WRITE.
- addr_o and pkt_size_o are stable from SEL until the next EOL. pkt_size_o is never changed mid-frame.
- en_i deassert mid-frame: the frame completes normally, then IDLE.
- Async reset mid-frame: everything returns to reset values immediately; in-flight writes are the wrapper's concern.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Optional Feature:
FB_WR_CTRL_STATS_EN: adds outputs frames_ok_o[15:0] and frames_drop_o[15:0]. Each increments (wrapping) on publish/drop_o respectively and clears on reset. Without the macro these ports and counters do not exist.

Decomposition:
fb_ctrl_pkg: state enum (IDLE, SEL, WAIT_SOF, WRITE, DRAIN), function frame_idx_w(FRAMES_CNT), default stride/size constants shared with the read controller. One sub-module, fb_frame_sel: combinational next-index selection with reader avoidance, reused by the read side.

Test Plan:
- base 0x0, frame_size 0x100000, stride 0x2000, line_size 64, lines 4, three clean frames -> addr_o sequence 0x100000,0x102000,0x104000,0x106000 then frame 2 at 0x200000, then frame 0 at 0x0; done_frame_o 1,2,0.
- rd_active_i=1, rd_frame_i=2 while frame 1 finishes -> next wr_frame_o=0; done_frame_o never equals 2 while held.
- Beats arrive before en_i and before SOF -> pass_o=0 for all; first passed beat has tuser=1.
- SOF asserted at line 2 of 4 -> frame completes, drop_o pulses once, done_frame_o unchanged.
- line_done_i delayed 50 cycles after final EOL -> stall_o held high for those cycles; publish the cycle outstanding reaches 0; EOL and line_done_i in the same cycle leave outstanding unchanged.
- rst_n_i asserted mid-WRITE, then released with en_i=1 -> outputs at reset values; next frame written to frame 1 at 0x100000.
